// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared state encodings and board defaults for the button debouncer
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // 1 ms of stability at the 12 MHz board clock
  localparam int DEFAULT_MAX_COUNT = 12000 - 1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with a configurable reset level
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces a raw push-button into a clean level plus press/release strobes
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int   COUNT_WIDTH = 20,
  parameter int   MAX_COUNT   = DEFAULT_MAX_COUNT,
  parameter logic ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_strobe
);

  localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(MAX_COUNT);

  db_state_t              state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   sync_q;
  logic                   pressed_s;

  // Reset to the idle pin level so leaving reset never looks like an edge
  sync_2ff #(
    .RESET_VALUE(ACTIVE_LOW)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync_q)
  );

  assign pressed_s = sync_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RELEASED;
      cnt            <= '0;
      level          <= 1'b0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      press          <= 1'b0;
      release_strobe <= 1'b0;
      case (state)
        RELEASED: begin
          if (pressed_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          // A bounce back wins over reaching the terminal count
          if (!pressed_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == TERMINAL) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + COUNT_WIDTH'(1);
          end
        end
        PRESSED: begin
          if (!pressed_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == TERMINAL) begin
            state          <= RELEASED;
            cnt            <= '0;
            level          <= 1'b0;
            release_strobe <= 1'b1;
          end else begin
            cnt <= cnt + COUNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic level;
  logic press;
  logic release_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .COUNT_WIDTH(4),
    .MAX_COUNT  (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .level         (level),
    .press         (press),
    .release_strobe(release_strobe)
  );

  typedef struct {
    logic btn;
    logic exp_level;
    logic exp_press;
    logic exp_rel;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int e,
                               input logic l, input logic p, input logic r);
    check($sformatf("%s level e%0d", tag, e), level, l);
    check($sformatf("%s press e%0d", tag, e), press, p);
    check($sformatf("%s release e%0d", tag, e), release_strobe, r);
  endtask

  initial begin
    // Clean press then clean release: 8 edges low, 8 edges high
    for (int i = 0; i < 8; i++) begin
      vecs[i].btn       = 1'b0;
      vecs[i].exp_level = (i + 1 >= 7);
      vecs[i].exp_press = (i + 1 == 7);
      vecs[i].exp_rel   = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      vecs[8+i].btn       = 1'b1;
      vecs[8+i].exp_level = (i + 1 < 7);
      vecs[8+i].exp_press = 1'b0;
      vecs[8+i].exp_rel   = (i + 1 == 7);
    end

    rst    = 1'b1;
    btn_in = 1'b1;
    #2;
    check_outputs("reset_state", 0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_outputs("reset_held", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_outputs("idle_after_reset", e, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      btn_in = vecs[i].btn;
      step();
      check_outputs("table", i, vecs[i].exp_level, vecs[i].exp_press, vecs[i].exp_rel);
    end

    // Press again, then assert reset asynchronously while press is high
    btn_in = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    check_outputs("pre_async_reset", 7, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_reset", 0, 1'b0, 1'b0, 1'b0);
    #3;
    btn_in = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check_outputs("post_reset_released", e, 1'b0, 1'b0, 1'b0);
    end

    // Bounce: 4 low / 1 high, five times, must never press
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 5; j++) begin
        btn_in = (j == 4);
        step();
        check_outputs($sformatf("bounce%0d", k), j, 1'b0, 1'b0, 1'b0);
      end
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_outputs("bounce_final", e, (e >= 7), (e == 7), 1'b0);
    end

    btn_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_outputs("bounce_release", e, (e < 7), 1'b0, (e == 7));
    end

    // Glitch sampled at edge 5 reaches the FSM exactly when cnt==3 (edge 7);
    // the FSM must fall back to RELEASED and restart, pressing only at edge 12
    for (int e = 1; e <= 14; e++) begin
      btn_in = (e == 5);
      step();
      check_outputs("glitch_terminal", e, (e >= 12), (e == 12), 1'b0);
    end

    btn_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_outputs("glitch_release", e, (e < 7), 1'b0, (e == 7));
    end

    // Button held through reset: a full debounce runs after deassertion
    btn_in = 1'b0;
    rst    = 1'b1;
    step();
    step();
    step();
    check_outputs("held_in_reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check_outputs("held_through_reset", e, (e >= 7), (e == 7), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, bouncy, asynchronous push-button input into a clean, clock-synchronous level.
- Also produces one-cycle press and release strobes.
- Sits directly upstream of the LED pulse/divider stages in top_design: replaces bare button inversion wherever a button drives logic, and supplies mode-step strobes for LED channels.

Parameters:
- COUNT_WIDTH, 20, width of the stability counter.
- MAX_COUNT, 12000 - 1, terminal count. Input must be stable for MAX_COUNT+1 consecutive cycles (1 ms at 12 MHz). Must satisfy 1 <= MAX_COUNT < 2**COUNT_WIDTH.
- ACTIVE_LOW, 1, 1 = button reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- btn_in  input  1  raw button pin, asynchronous to clk
- level  output  1  debounced state, 1 = pressed (polarity-normalised)
- press  output  1  one-cycle strobe on debounced press
- release  output  1  one-cycle strobe on debounced release

Behaviour:
- One clock (clk). Reset rst is asynchronous, active-high; all flops clear immediately on rst assertion, independent of clk.
- Reset values:
  - level=0, press=0, release=0, counter=0, state=RELEASED.
  - Both synchroniser flops reset to the released pin value (1 if ACTIVE_LOW else 0), so no spurious edge appears after reset.
- Synchroniser:
  - 2-flop chain on btn_in.
  - pressed_s = sync2 XOR ACTIVE_LOW.
- FSM, 4 states, counter `cnt`:
  - RELEASED:
    - pressed_s=1 -> PRESS_WAIT, cnt<=0.
    - else stay.
  - PRESS_WAIT:
    - pressed_s=0 -> RELEASED, cnt<=0 (bounce rejected, no strobe).
    - else if cnt==MAX_COUNT -> PRESSED, level<=1, press<=1.
    - else cnt<=cnt+1.
  - PRESSED:
    - pressed_s=0 -> RELEASE_WAIT, cnt<=0.
    - else stay.
  - RELEASE_WAIT:
    - pressed_s=1 -> PRESSED, cnt<=0 (no strobe).
    - else if cnt==MAX_COUNT -> RELEASED, level<=0, release<=1.
    - else cnt<=cnt+1.
- Strobes:
  - press and release are registered and high for exactly one cycle.
  - They are never simultaneously high.
  - Each is cleared on the cycle after it is asserted.
- Latency:
  - Count edges from the first clk edge at which sync1 samples the new stable value, numbered edge 1.
  - level and the strobe update on edge MAX_COUNT+4.
- Counter:
  - Counts only in the WAIT states and never exceeds MAX_COUNT, so no wrap is possible.
  - Comparison is against MAX_COUNT truncated to COUNT_WIDTH.
- Bounce that returns to the prior level at any cycle, including the cycle where cnt==MAX_COUNT, is seen by the FSM as pressed_s changing. That change takes priority over the terminal count: no transition, no strobe.
- Reset mid-debounce: all state is discarded. If the button is held through reset deassertion, a full debounce runs afterwards and press fires normally.
- level changes only together with a strobe.

Decomposition:
- Shared package (Verilog include) holds:
  - 2-bit state encodings: RELEASED=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - Default MAX_COUNT for the 12 MHz board clock.
- One sub-module, sync_2ff: 2-flop synchroniser with reset-value parameter, reusable for other pins.

Test Plan:
All scenarios use MAX_COUNT=3, COUNT_WIDTH=4, ACTIVE_LOW=1.
- Reset: assert rst mid-cycle with btn_in=0 held -> level/press/release go 0 immediately, without a clk edge. Release rst with btn_in=1 -> no strobe ever.
- Clean press: btn_in 1->0 and held -> press high for exactly 1 cycle and level=1 on edge 7; level stays 1 while held.
- Bounce rejection: btn_in low for 4 cycles, high 1 cycle, repeated 5 times, then held low -> single press only after the final stable low, on edge 7 of the final low.
- Clean release after press: btn_in 0->1 held -> release pulse 1 cycle on edge 7; level=0.
- Glitch at terminal count: while in PRESS_WAIT, toggle btn_in high for one cycle timed to reach pressed_s when cnt==3 -> no press, state RELEASED, level=0.
- Held through reset: btn_in=0 during rst, deassert rst -> press fires once on edge 7 after deassertion; no release strobe.
